fpu_issue_ctrl: RTL and testbench
=================================

// Module: fpu_issue_ctrl
// PURPOSE
//   Sequences a multi-cycle FPU core beside the integer Execute stage of the 5-stage ARM pipeline.
//   - Accepts one FPU op at a time from Execute.
//   - Stalls the front end while the FPU is busy.
//   - Publishes the pending destination register so the hazard unit can detect RAW hazards.
//   - Shares the single register-file write port with the integer writeback; integer writeback has priority.
// PARAMETERS
//   DW           32   operand/result width
//   AW           4    register address width
//   TIMEOUT_CYC  64   max RUN cycles before abort (FPU_TIMEOUT_EN only)
//   CNTW         7    RUN cycle counter width; must hold TIMEOUT_CYC
// PORTS
//   CLK            in   1   clock, rising edge
//   Reset          in   1   asynchronous, active-low reset
//   issue_valid    in   1   FPU instr in Execute, condition passed
//   issue_op       in   1   0=FADD 1=FMUL
//   issue_wa3      in   AW  destination register
//   issue_a        in   DW  forwarded SrcA
//   issue_b        in   DW  forwarded SrcB
//   issue_ready    out  1   controller can accept an issue this cycle
//   stall_req      out  1   stall F/D and bubble E (=issue_valid & ~issue_ready)
//   fpu_start      out  1   one-cycle start pulse to the FPU core
//   fpu_op         out  1   latched op
//   fpu_a, fpu_b   out  DW  latched operands, stable through RUN
//   fpu_done       in   1   FPU core result valid (one-cycle pulse)
//   fpu_result     in   DW  FPU core result
//   int_regwrite_w in   1   integer writeback uses the port this cycle
//   pend_valid     out  1   FPU destination outstanding
//   pend_wa3       out  AW  outstanding destination register
//   wb_en          out  1   FPU write granted this cycle
//   wb_addr        out  AW  FPU write address
//   wb_data        out  DW  FPU write data
//   fpu_err        out  1   sticky timeout flag
// BEHAVIOUR
//   Reset (Reset=0, async):
//     state=IDLE; all outputs 0 except issue_ready=1; latched operands/result/counter cleared.
//   FSM IDLE -> RUN -> WB -> IDLE.
//   IDLE:
//     - issue_ready=1.
//     - issue_valid at edge: latch op/a/b/wa3, go RUN, pend_valid=1.
//     - fpu_done in IDLE is ignored.
//   RUN:
//     - fpu_start=1 in the first RUN cycle only; counter cleared on entry, +1 per cycle.
//     - fpu_done sampled every RUN cycle, including the start cycle.
//     - fpu_done=1: capture fpu_result, go WB.
//   WB:
//     - wb_en = ~int_regwrite_w (combinational); wb_addr=pend_wa3, wb_data=captured result.
//     - Grant cycle (wb_en=1): go IDLE; pend_valid drops at that edge.
//     - int_regwrite_w=1: stay in WB and hold data; no limit on deferral.
//   issue_ready=0 in RUN and WB. A new issue_valid stalls (stall_req=1) until the cycle after the
//     grant. issue inputs are ignored while not ready; upstream holds them under stall.
//   pend_valid=1 from the cycle after accept through the grant cycle inclusive.
//   Min issue-to-writeback latency: 2 cycles (done in start cycle, no deferral). Back-to-back issue: 1 idle cycle.
//   Reset mid-RUN or mid-WB: operation discarded, no writeback; a later fpu_done is ignored.
// CONFIGURATION
//   FPU_TIMEOUT_EN defined:
//     - In RUN, counter reaching TIMEOUT_CYC without fpu_done -> IDLE, no writeback, pend_valid=0.
//     - fpu_err set until reset.
//   FPU_TIMEOUT_EN undefined:
//     - No timeout logic; RUN waits indefinitely; fpu_err tied 0.
// TESTING
//   1. Release reset -> issue_ready=1, stall_req=0, wb_en=0, pend_valid=0, fpu_err=0.
//   2. FADD a=0x3F800000 b=0x40000000 wa3=3, done 3 cycles after start with 0x40400000
//      -> one fpu_start pulse; wb_en=1, wb_addr=3, wb_data=0x40400000 next cycle; pend_valid high throughout.
//   3. Done lands while int_regwrite_w=1 for 2 cycles -> wb_en=0 for those 2 cycles, then wb_en=1
//      with the held data; no other writes.
//   4. Second issue_valid during RUN -> stall_req=1 until the cycle after the grant, then accepted
//      with the new operands.
//   5. Reset asserted mid-RUN, fpu_done after release -> no wb_en, pend_valid=0, back in IDLE.
//   6. FPU_TIMEOUT_EN, fpu_done never arrives -> IDLE after 64 RUN cycles, fpu_err=1 sticky, wb_en never 1.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback sequencer for a multi-cycle FPU core beside the integer Execute stage.
// Optional abort of runaway operations when FPU_TIMEOUT_EN is defined.
module fpu_issue_ctrl #(
  parameter int DW          = 32,
  parameter int AW          = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNTW        = 7
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          issue_valid,
  input  logic          issue_op,
  input  logic [AW-1:0] issue_wa3,
  input  logic [DW-1:0] issue_a,
  input  logic [DW-1:0] issue_b,
  output logic          issue_ready,
  output logic          stall_req,
  output logic          fpu_start,
  output logic          fpu_op,
  output logic [DW-1:0] fpu_a,
  output logic [DW-1:0] fpu_b,
  input  logic          fpu_done,
  input  logic [DW-1:0] fpu_result,
  input  logic          int_regwrite_w,
  output logic          pend_valid,
  output logic [AW-1:0] pend_wa3,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          fpu_err
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0]   wa3_q;
  logic [DW-1:0]   result_q;
  logic            accept;
  logic            timeout_hit;

  assign accept = (state == IDLE) && issue_valid;

`ifdef FPU_TIMEOUT_EN
  // The last permitted RUN cycle is the one where the counter reads TIMEOUT_CYC-1.
  assign timeout_hit = (state == RUN) && !fpu_done && (cnt == CNTW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)           fpu_err <= 1'b0;
    else if (timeout_hit) fpu_err <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign fpu_err     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_valid) state_nxt = RUN;
      RUN:     if (fpu_done) state_nxt = WB;
               else if (timeout_hit) state_nxt = IDLE;
      WB:      if (!int_regwrite_w) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_ready = 1'b0;
    fpu_start   = 1'b0;
    pend_valid  = 1'b0;
    wb_en       = 1'b0;
    case (state)
      IDLE:    issue_ready = 1'b1;
      RUN: begin
        fpu_start  = (cnt == '0);
        pend_valid = 1'b1;
      end
      WB: begin
        pend_valid = 1'b1;
        wb_en      = !int_regwrite_w;
      end
      default: issue_ready = 1'b0;
    endcase
    stall_req = issue_valid && !issue_ready;
  end

  // NOTE: datapath registers are reset too, so a discarded operation leaves no stale operands visible.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fpu_op   <= 1'b0;
      fpu_a    <= '0;
      fpu_b    <= '0;
      wa3_q    <= '0;
      result_q <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        fpu_op <= issue_op;
        fpu_a  <= issue_a;
        fpu_b  <= issue_b;
        wa3_q  <= issue_wa3;
      end
      // Saturate so an unbounded RUN never wraps back to zero and re-pulses fpu_start.
      if (state != RUN)                     cnt <= '0;
      else if (cnt != CNTW'(TIMEOUT_CYC))   cnt <= cnt + 1'b1;
      if ((state == RUN) && fpu_done)       result_q <= fpu_result;
    end
  end

  assign pend_wa3 = wa3_q;
  assign wb_addr  = wa3_q;
  assign wb_data  = result_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed, table-driven bench for fpu_issue_ctrl; timeout sequence depends on FPU_TIMEOUT_EN.
module tb_fpu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        issue_valid = 1'b0, issue_op = 1'b0;
  logic [3:0]  issue_wa3 = '0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic        issue_ready, stall_req, fpu_start, fpu_op;
  logic [31:0] fpu_a, fpu_b;
  logic        fpu_done = 1'b0;
  logic [31:0] fpu_result = '0;
  logic        int_regwrite_w = 1'b0;
  logic        pend_valid, wb_en, fpu_err;
  logic [3:0]  pend_wa3, wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl dut (
    .CLK(CLK), .Reset(Reset),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_wa3(issue_wa3),
    .issue_a(issue_a), .issue_b(issue_b),
    .issue_ready(issue_ready), .stall_req(stall_req), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .int_regwrite_w(int_regwrite_w),
    .pend_valid(pend_valid), .pend_wa3(pend_wa3),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .fpu_err(fpu_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv, op;
    logic [3:0]  wa3;
    logic [31:0] a, b;
    logic        done;
    logic [31:0] res;
    logic        iw;
    logic        e_ready, e_stall, e_start, e_pend, e_wb;
    logic [3:0]  e_wa3;
    logic [31:0] e_wd, e_fa, e_fb;
    logic        e_op;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic iv, input logic op, input logic [3:0] wa3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic done, input logic [31:0] res, input logic iw);
    issue_valid = iv; issue_op = op; issue_wa3 = wa3; issue_a = a; issue_b = b;
    fpu_done = done; fpu_result = res; int_regwrite_w = iw;
  endtask

  initial begin
    int  n;
    bit  dropped, saw_wb;

    //           iv op wa3  a             b             done res           iw   rdy stl str pnd wb wa3  wd            fa            fb            op
    vecs[0]  = '{1, 0, 3, 32'h3F800000, 32'h40000000, 0, 32'h0,        0,   1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0};
    vecs[1]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 1, 1, 0, 3, 32'h0,        32'h3F800000, 32'h40000000, 0};
    vecs[2]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 0, 3, 32'h0,        32'h3F800000, 32'h40000000, 0};
    vecs[3]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 0, 3, 32'h0,        32'h3F800000, 32'h40000000, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h40400000, 0,   0, 0, 0, 1, 0, 3, 32'h0,        32'h3F800000, 32'h40000000, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 1, 3, 32'h40400000, 32'h3F800000, 32'h40000000, 0};
    vecs[6]  = '{1, 1, 5, 32'h11111111, 32'h22222222, 0, 32'h0,        0,   1, 0, 0, 0, 0, 3, 32'h40400000, 32'h3F800000, 32'h40000000, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,        32'h0,        1, 32'hAAAA5555, 0,   0, 0, 1, 1, 0, 5, 32'h40400000, 32'h11111111, 32'h22222222, 1};
    vecs[8]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1,   0, 0, 0, 1, 0, 5, 32'hAAAA5555, 32'h11111111, 32'h22222222, 1};
    vecs[9]  = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1,   0, 0, 0, 1, 0, 5, 32'hAAAA5555, 32'h11111111, 32'h22222222, 1};
    vecs[10] = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 1, 5, 32'hAAAA5555, 32'h11111111, 32'h22222222, 1};
    vecs[11] = '{1, 0, 2, 32'h1,        32'h2,        0, 32'h0,        0,   1, 0, 0, 0, 0, 5, 32'hAAAA5555, 32'h11111111, 32'h22222222, 1};
    vecs[12] = '{1, 1, 9, 32'hA,        32'hB,        0, 32'h0,        0,   0, 1, 1, 1, 0, 2, 32'hAAAA5555, 32'h1,        32'h2,        0};
    vecs[13] = '{1, 1, 9, 32'hA,        32'hB,        1, 32'h3,        0,   0, 1, 0, 1, 0, 2, 32'hAAAA5555, 32'h1,        32'h2,        0};
    vecs[14] = '{1, 1, 9, 32'hA,        32'hB,        0, 32'h0,        0,   0, 1, 0, 1, 1, 2, 32'h3,        32'h1,        32'h2,        0};
    vecs[15] = '{1, 1, 9, 32'hA,        32'hB,        0, 32'h0,        0,   1, 0, 0, 0, 0, 2, 32'h3,        32'h1,        32'h2,        0};
    vecs[16] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'h55,       0,   0, 0, 1, 1, 0, 9, 32'h3,        32'hA,        32'hB,        1};
    vecs[17] = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   0, 0, 0, 1, 1, 9, 32'h55,       32'hA,        32'hB,        1};
    vecs[18] = '{0, 0, 0, 32'h0,        32'h0,        1, 32'hDEAD,     0,   1, 0, 0, 0, 0, 9, 32'h55,       32'hA,        32'hB,        1};
    vecs[19] = '{0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0,   1, 0, 0, 0, 0, 9, 32'h55,       32'hA,        32'hB,        1};

    // Reset state
    #13;
    check("rst issue_ready", 32'(issue_ready), 32'd1);
    check("rst stall_req",   32'(stall_req),   32'd0);
    check("rst wb_en",       32'(wb_en),       32'd0);
    check("rst pend_valid",  32'(pend_valid),  32'd0);
    check("rst fpu_err",     32'(fpu_err),     32'd0);
    check("rst fpu_start",   32'(fpu_start),   32'd0);
    check("rst wb_data",     wb_data,          32'd0);
    Reset = 1'b1;
    next_cycle();

    // Table: normal op, deferred writeback, stall under a busy FPU, done ignored in IDLE
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].wa3, vecs[i].a, vecs[i].b,
            vecs[i].done, vecs[i].res, vecs[i].iw);
      #4;
      check($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d stall_req", i),   32'(stall_req),   32'(vecs[i].e_stall));
      check($sformatf("v%0d fpu_start", i),   32'(fpu_start),   32'(vecs[i].e_start));
      check($sformatf("v%0d pend_valid", i),  32'(pend_valid),  32'(vecs[i].e_pend));
      check($sformatf("v%0d wb_en", i),       32'(wb_en),       32'(vecs[i].e_wb));
      check($sformatf("v%0d pend_wa3", i),    32'(pend_wa3),    32'(vecs[i].e_wa3));
      check($sformatf("v%0d wb_addr", i),     32'(wb_addr),     32'(vecs[i].e_wa3));
      check($sformatf("v%0d wb_data", i),     wb_data,          vecs[i].e_wd);
      check($sformatf("v%0d fpu_a", i),       fpu_a,            vecs[i].e_fa);
      check($sformatf("v%0d fpu_b", i),       fpu_b,            vecs[i].e_fb);
      check($sformatf("v%0d fpu_op", i),      32'(fpu_op),      32'(vecs[i].e_op));
      next_cycle();
    end

    // Reset mid-RUN discards the op; a late fpu_done must not produce a writeback
    drive(1, 1, 4'd6, 32'h12345678, 32'h9ABCDEF0, 0, 32'h0, 0);
    next_cycle();
    drive(0, 0, 4'd0, 32'h0, 32'h0, 0, 32'h0, 0);
    next_cycle();
    #4;
    check("midrun pend_valid before reset", 32'(pend_valid), 32'd1);
    Reset = 1'b0;
    #1;
    check("midrun async pend_valid", 32'(pend_valid),  32'd0);
    check("midrun async issue_ready", 32'(issue_ready), 32'd1);
    check("midrun async fpu_a",       fpu_a,            32'd0);
    next_cycle();
    Reset = 1'b1;
    drive(0, 0, 4'd0, 32'h0, 32'h0, 1, 32'h77, 0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check($sformatf("postrst%0d wb_en", i),       32'(wb_en),       32'd0);
      check($sformatf("postrst%0d pend_valid", i),  32'(pend_valid),  32'd0);
      check($sformatf("postrst%0d issue_ready", i), 32'(issue_ready), 32'd1);
      check($sformatf("postrst%0d wb_data", i),     wb_data,          32'd0);
      next_cycle();
      fpu_done = 1'b0;
    end

    // Long RUN with no fpu_done
    drive(1, 0, 4'd8, 32'hCAFE0001, 32'hCAFE0002, 0, 32'h0, 0);
    next_cycle();
    drive(0, 0, 4'd0, 32'h0, 32'h0, 0, 32'h0, 0);
    n = 0;
    dropped = 1'b0;
    saw_wb = 1'b0;
    for (int i = 0; i < 200 && !dropped; i++) begin
      #4;
      if (pend_valid) n++;
      else dropped = 1'b1;
      if (wb_en) saw_wb = 1'b1;
      next_cycle();
    end
    check("long run never writes back", 32'(saw_wb), 32'd0);
`ifdef FPU_TIMEOUT_EN
    check("timeout RUN cycles", 32'(n),        32'd64);
    check("timeout fpu_err",    32'(fpu_err),  32'd1);
    check("timeout issue_ready", 32'(issue_ready), 32'd1);
    // A following op still completes; the error flag stays set
    drive(1, 1, 4'd4, 32'h1, 32'h1, 0, 32'h0, 0);
    next_cycle();
    drive(0, 0, 4'd0, 32'h0, 32'h0, 1, 32'hBEEF, 0);
    next_cycle();
    fpu_done = 1'b0;
    #4;
    check("after timeout wb_en",   32'(wb_en),   32'd1);
    check("after timeout wb_data", wb_data,      32'hBEEF);
    check("after timeout fpu_err", 32'(fpu_err), 32'd1);
    next_cycle();
`else
    check("no timeout RUN held", 32'(n),       32'd200);
    check("no timeout fpu_err",  32'(fpu_err), 32'd0);
    check("no timeout single start", 32'(fpu_start), 32'd0);
    fpu_done = 1'b1; fpu_result = 32'hBEEF;
    next_cycle();
    fpu_done = 1'b0;
    #4;
    check("late done wb_en",   32'(wb_en),   32'd1);
    check("late done wb_addr", 32'(wb_addr), 32'd8);
    check("late done wb_data", wb_data,      32'hBEEF);
    next_cycle();
`endif
    #4;
    check("final issue_ready", 32'(issue_ready), 32'd1);
    check("final pend_valid",  32'(pend_valid),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
